// File: rtl/mcpu_vram_dma.sv
// mcpu_vram_dma: copies DRAM low bytes into VRAM using bus cycles the CPU leaves idle.
// Define MCPU_DMA_FILL_EN to add constant-fill transfers and vblank gating of all strobes.
module mcpu_vram_dma #(
  parameter int DATA_WIDTH = 16,
  parameter int SRC_AW     = 14,
  parameter int DST_AW     = 13,
  parameter int LEN_W      = 14
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  abort,
  input  logic [SRC_AW-1:0]     cfg_src,
  input  logic [DST_AW-1:0]     cfg_dst,
  input  logic [LEN_W-1:0]      cfg_len,
  input  logic                  cfg_fill,
  input  logic [7:0]            cfg_fill_value,
  input  logic                  vblank,
  input  logic                  cpu_req,
  output logic [SRC_AW-1:0]     dram_addr,
  output logic                  dram_re,
  input  logic [DATA_WIDTH-1:0] dram_data,
  output logic [DST_AW-1:0]     vram_addr,
  output logic [7:0]            vram_data,
  output logic                  vram_we,
  output logic                  bus_owner,
  output logic                  busy,
  output logic                  done
);

  typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;

  state_t              state, next_state;
  logic [SRC_AW-1:0]   src_ptr;
  logic [DST_AW-1:0]   dst_ptr;
  logic [LEN_W-1:0]    remaining;
  logic [7:0]          data_lat;
  logic                fill_mode;
  logic                bus_free;
  logic                start_fill;
  logic [7:0]          fill_byte;
  logic                unused_inputs;

`ifdef MCPU_DMA_FILL_EN
  // Outside vblank the DMA behaves as if the CPU owned every cycle.
  assign bus_free      = !cpu_req && vblank;
  assign start_fill    = cfg_fill;
  assign fill_byte     = cfg_fill_value;
  assign unused_inputs = &{1'b0, dram_data[DATA_WIDTH-1:8]};
`else
  assign bus_free      = !cpu_req;
  assign start_fill    = 1'b0;
  assign fill_byte     = 8'h00;
  assign unused_inputs = &{1'b0, cfg_fill, cfg_fill_value, vblank, dram_data[DATA_WIDTH-1:8]};
`endif

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE: begin
        if (start) begin
          if (cfg_len == '0)   next_state = DONE;
          else if (start_fill) next_state = WRITE;
          else                 next_state = READ;
        end
      end
      READ: begin
        if (abort)         next_state = IDLE;
        else if (bus_free) next_state = WAIT;
      end
      WAIT: begin
        if (abort) next_state = IDLE;
        else       next_state = WRITE;
      end
      WRITE: begin
        if (abort)                          next_state = IDLE;
        else if (bus_free) begin
          if (remaining == LEN_W'(1))       next_state = DONE;
          else if (fill_mode)               next_state = WRITE;
          else                              next_state = READ;
        end
      end
      DONE:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // Strobes are suppressed in any cycle where abort or reset will cancel the transfer.
  always_comb begin
    dram_re   = 1'b0;
    vram_we   = 1'b0;
    if (!reset && !abort && bus_free) begin
      dram_re = (state == READ);
      vram_we = (state == WRITE);
    end
    bus_owner = dram_re | vram_we;
    busy      = (state == READ) || (state == WAIT) || (state == WRITE);
    done      = (state == DONE);
  end

  assign dram_addr = src_ptr;
  assign vram_addr = dst_ptr;
  assign vram_data = data_lat;

  always_ff @(posedge clk) begin
    if (reset) begin
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      data_lat  <= '0;
      fill_mode <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && cfg_len != '0) begin
            src_ptr   <= cfg_src;
            dst_ptr   <= cfg_dst;
            remaining <= cfg_len;
            fill_mode <= start_fill;
            if (start_fill) data_lat <= fill_byte;
          end
        end
        WAIT: data_lat <= dram_data[7:0];
        WRITE: begin
          if (vram_we) begin
            src_ptr   <= src_ptr + SRC_AW'(1);
            dst_ptr   <= dst_ptr + DST_AW'(1);
            remaining <= remaining - LEN_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mcpu_vram_dma.sv
// Directed self-checking bench for mcpu_vram_dma with behavioural DRAM and VRAM models.
// Fill-mode vectors are compiled in when MCPU_DMA_FILL_EN is defined.
module tb_mcpu_vram_dma;

  logic        clk = 1'b0;
  logic        reset, start, abort, cfg_fill, vblank, cpu_req;
  logic [13:0] cfg_src, cfg_len, dram_addr;
  logic [12:0] cfg_dst, vram_addr;
  logic [7:0]  cfg_fill_value, vram_data;
  logic [15:0] dram_data;
  logic        dram_re, vram_we, bus_owner, busy, done;

  logic [15:0] mem  [0:16383];
  logic [7:0]  vram [0:8191];
  logic [7:0]  exp_bytes [0:3];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  mcpu_vram_dma dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort),
    .cfg_src(cfg_src), .cfg_dst(cfg_dst), .cfg_len(cfg_len),
    .cfg_fill(cfg_fill), .cfg_fill_value(cfg_fill_value), .vblank(vblank),
    .cpu_req(cpu_req), .dram_addr(dram_addr), .dram_re(dram_re),
    .dram_data(dram_data), .vram_addr(vram_addr), .vram_data(vram_data),
    .vram_we(vram_we), .bus_owner(bus_owner), .busy(busy), .done(done)
  );

  // DRAM returns data one cycle after the read strobe; VRAM writes on the strobe edge.
  always @(posedge clk) begin
    if (dram_re) dram_data <= mem[dram_addr];
    if (vram_we) vram[vram_addr] <= vram_data;
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic checkCycle(input string tag, input int c, input bit e_re, input bit e_we,
                            input bit e_busy, input bit e_done);
    checkOutput($sformatf("%s c%0d dram_re", tag, c), {31'd0, dram_re}, {31'd0, e_re});
    checkOutput($sformatf("%s c%0d vram_we", tag, c), {31'd0, vram_we}, {31'd0, e_we});
    checkOutput($sformatf("%s c%0d bus_owner", tag, c), {31'd0, bus_owner}, {31'd0, e_re | e_we});
    checkOutput($sformatf("%s c%0d busy", tag, c), {31'd0, busy}, {31'd0, e_busy});
    checkOutput($sformatf("%s c%0d done", tag, c), {31'd0, done}, {31'd0, e_done});
  endtask

  // Presents one start pulse; returns at cycle 1 of the transfer.
  task automatic applyStimulus(input logic [13:0] src, input logic [12:0] dst, input logic [13:0] len,
                               input logic fill, input logic [7:0] fv);
    cfg_src        = src;
    cfg_dst        = dst;
    cfg_len        = len;
    cfg_fill       = fill;
    cfg_fill_value = fv;
    start          = 1'b1;
    step();
    start          = 1'b0;
  endtask

  // Copy of n bytes; cpu_req held for cycles 1..stall plus one pulse during a later WAIT.
  task automatic runCopy(input string tag, input logic [13:0] src, input logic [12:0] dst,
                         input int n, input int stall, input bit restart, input logic fill);
    int k;
    logic [13:0] sa;
    logic [12:0] da;
    bit e_re, e_we;
    applyStimulus(src, dst, 14'(n), fill, 8'h5A);
    for (int c = 1; c <= 3 * n + stall + 2; c++) begin
      cpu_req = (c <= stall) || (stall > 0 && c == stall + 5);
      start   = restart && (c == 2);
      if (restart && c == 2) begin
        cfg_src = 14'h0300;
        cfg_dst = 13'h0010;
        cfg_len = 14'd1;
      end
      #1;
      k    = c - stall;
      e_re = (k >= 1) && (k <= 3 * n - 2) && (k % 3 == 1);
      e_we = (k >= 3) && (k <= 3 * n) && (k % 3 == 0);
      checkCycle(tag, c, e_re, e_we, c <= 3 * n + stall, c == 3 * n + stall + 1);
      if (e_re) begin
        sa = src + 14'((k - 1) / 3);
        checkOutput($sformatf("%s c%0d dram_addr", tag, c), {18'd0, dram_addr}, {18'd0, sa});
      end
      if (e_we) begin
        da = dst + 13'(k / 3 - 1);
        sa = src + 14'(k / 3 - 1);
        checkOutput($sformatf("%s c%0d vram_addr", tag, c), {19'd0, vram_addr}, {19'd0, da});
        checkOutput($sformatf("%s c%0d vram_data", tag, c), {24'd0, vram_data}, {24'd0, mem[sa][7:0]});
      end
      step();
    end
    cpu_req = 1'b0;
    start   = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 16384; i++) mem[i] = 16'(i * 16'h0105 + 16'h3C00);
    for (int i = 0; i < 8192; i++) vram[i] = 8'h00;
    mem[14'h0100] = 16'hBE11;
    mem[14'h0101] = 16'h7F22;
    mem[14'h0102] = 16'h0033;
    mem[14'h0103] = 16'hFF44;
    mem[14'h3FFF] = 16'h12C7;
    mem[14'h0000] = 16'h3456;
    exp_bytes[0] = 8'h11;
    exp_bytes[1] = 8'h22;
    exp_bytes[2] = 8'h33;
    exp_bytes[3] = 8'h44;

    reset = 1'b1; start = 1'b0; abort = 1'b0; cpu_req = 1'b0; vblank = 1'b1;
    cfg_src = '0; cfg_dst = '0; cfg_len = '0; cfg_fill = 1'b0; cfg_fill_value = '0;
    dram_data = '0;
    step(); step(); step();
    reset = 1'b0;
    #1;
    checkCycle("reset", 0, 1'b0, 1'b0, 1'b0, 1'b0);
    checkOutput("reset dram_addr", {18'd0, dram_addr}, 32'd0);
    checkOutput("reset vram_addr", {19'd0, vram_addr}, 32'd0);
    checkOutput("reset vram_data", {24'd0, vram_data}, 32'd0);
    step();

    $display("[TB] uncontended copy");
    runCopy("copy", 14'h0100, 13'h0040, 4, 0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("copy vram[%0h]", 13'h0040 + 13'(i)), {24'd0, vram[13'h0040 + 13'(i)]}, {24'd0, exp_bytes[i]});
    checkOutput("copy vram past end", {24'd0, vram[13'h0044]}, 32'd0);

    $display("[TB] copy under cpu contention");
    runCopy("contend", 14'h0100, 13'h0080, 4, 5, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("contend vram[%0h]", 13'h0080 + 13'(i)), {24'd0, vram[13'h0080 + 13'(i)]}, {24'd0, exp_bytes[i]});

    $display("[TB] zero length");
    applyStimulus(14'h0100, 13'h0040, 14'd0, 1'b0, 8'h00);
    for (int c = 1; c <= 3; c++) begin
      #1;
      checkCycle("zero", c, 1'b0, 1'b0, 1'b0, c == 1);
      step();
    end

    $display("[TB] pointer wrap");
    runCopy("wrap", 14'h3FFF, 13'h1FFF, 2, 0, 1'b0, 1'b0);
    checkOutput("wrap vram[1fff]", {24'd0, vram[13'h1FFF]}, 32'hC7);
    checkOutput("wrap vram[0000]", {24'd0, vram[13'h0000]}, 32'h56);

    $display("[TB] abort mid transfer");
    applyStimulus(14'h0200, 13'h0100, 14'd8, 1'b0, 8'h00);
    for (int c = 1; c <= 10; c++) begin
      abort = (c == 4);
      #1;
      checkCycle("abort", c, c == 1, c == 3, c <= 4, 1'b0);
      step();
    end
    abort = 1'b0;

    $display("[TB] reset mid transfer");
    applyStimulus(14'h0200, 13'h0100, 14'd8, 1'b0, 8'h00);
    for (int c = 1; c <= 10; c++) begin
      reset = (c == 4);
      #1;
      checkCycle("midreset", c, c == 1, c == 3, c <= 4, 1'b0);
      step();
    end
    reset = 1'b0;

    $display("[TB] start while busy");
    runCopy("restart", 14'h0100, 13'h00C0, 4, 0, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("restart vram[%0h]", 13'h00C0 + 13'(i)), {24'd0, vram[13'h00C0 + 13'(i)]}, {24'd0, exp_bytes[i]});

`ifdef MCPU_DMA_FILL_EN
    $display("[TB] fill during vblank");
    applyStimulus(14'h0000, 13'h0010, 14'd3, 1'b1, 8'hAA);
    for (int c = 1; c <= 5; c++) begin
      #1;
      checkCycle("fill", c, 1'b0, c <= 3, c <= 3, c == 4);
      if (c <= 3) begin
        checkOutput($sformatf("fill c%0d vram_addr", c), {19'd0, vram_addr}, 32'h10 + 32'(c - 1));
        checkOutput($sformatf("fill c%0d vram_data", c), {24'd0, vram_data}, 32'hAA);
      end
      step();
    end

    $display("[TB] fill gated by vblank");
    applyStimulus(14'h0000, 13'h0020, 14'd3, 1'b1, 8'hAA);
    for (int c = 1; c <= 15; c++) begin
      vblank = (c > 10);
      #1;
      checkCycle("fillgate", c, 1'b0, c >= 11 && c <= 13, c <= 13, c == 14);
      step();
    end
    vblank = 1'b1;
    checkOutput("fillgate vram[22]", {24'd0, vram[13'h0022]}, 32'hAA);
`else
    $display("[TB] fill inputs ignored");
    vblank = 1'b0;
    runCopy("nofill", 14'h0100, 13'h0060, 4, 0, 1'b0, 1'b1);
    vblank = 1'b1;
    for (int i = 0; i < 4; i++)
      checkOutput($sformatf("nofill vram[%0h]", 13'h0060 + 13'(i)), {24'd0, vram[13'h0060 + 13'(i)]}, {24'd0, exp_bytes[i]});
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mcpu_vram_dma.md
Name: mcpu_vram_dma

Overview:
DMA controller that copies a block of bytes from DRAM (word low byte) into VRAM, so the CPU need not move pixel/tile data itself.
Shares the single CPU address/data bus with the core: the CPU always wins, and DMA uses only cycles where the core makes no memory access.
Sits in mcpu_top beside mcpu_dram and mcpu_gpu. The top muxes cpu_addr/dram_we/vram_we with this block's strobes, selected by bus_owner.

Parameters:
DATA_WIDTH, 16, DRAM word width; only bits [7:0] are copied.
SRC_AW, 14, DRAM address width; source pointer wraps modulo 2^SRC_AW.
DST_AW, 13, VRAM address width; destination pointer wraps modulo 2^DST_AW.
LEN_W, 14, transfer length counter width.

Ports:
clk  in  1  system clock; all state on rising edge
reset  in  1  synchronous, active-high; forces IDLE
start  in  1  one-cycle pulse; latches cfg_* when idle
abort  in  1  stop the current transfer, no done pulse
cfg_src  in  SRC_AW  first DRAM word address
cfg_dst  in  DST_AW  first VRAM byte address
cfg_len  in  LEN_W  number of bytes to copy (0 allowed)
cfg_fill  in  1  fill mode select (see Optional Feature)
cfg_fill_value  in  8  fill byte (see Optional Feature)
vblank  in  1  vertical blanking (see Optional Feature)
cpu_req  in  1  core accesses memory this cycle (dram_re|dram_we)
dram_addr  out  SRC_AW  DMA DRAM read address
dram_re  out  1  DMA DRAM read strobe
dram_data  in  DATA_WIDTH  DRAM read data; valid 1 cycle after the strobe
vram_addr  out  DST_AW  DMA VRAM write address
vram_data  out  8  byte to write
vram_we  out  1  DMA VRAM write strobe
bus_owner  out  1  1 = DMA drives the bus this cycle
busy  out  1  transfer in progress
done  out  1  one-cycle completion pulse

Behaviour:
- States: IDLE, READ, WAIT, WRITE, DONE. Registers: src_ptr, dst_ptr, remaining, data_lat[7:0].
- Reset: state=IDLE, all pointers/counters 0. Outputs after reset: busy=0, done=0, dram_re=0, vram_we=0, bus_owner=0, addresses/data 0.
- IDLE:
  - start=1 with cfg_len=0 -> DONE.
  - start=1 with cfg_len>0 -> latch the cfg_* inputs, go to READ.
  - start while not IDLE is ignored.
- READ:
  - If cpu_req=0: dram_re=1 and bus_owner=1 (combinational); go to WAIT.
  - If cpu_req=1: all strobes 0; stay in READ (stall).
- WAIT: unconditional; capture data_lat <= dram_data[7:0]; no strobes; next state WRITE. A CPU access during WAIT is legal and does not corrupt the capture.
- WRITE:
  - If cpu_req=0: vram_we=1, vram_data=data_lat, bus_owner=1. Then dst_ptr+1 and src_ptr+1, each wrapping at its width, and remaining-1. Next state is DONE if remaining was 1, else READ.
  - If cpu_req=1: stall in WRITE.
- DONE: done=1 for exactly one cycle; -> IDLE.
- busy=1 in READ, WAIT and WRITE; busy=0 in IDLE and DONE.
- Uncontended timing: 3 cycles per byte. With start sampled at edge 0, the last write is at cycle 3N and done is at cycle 3N+1.
- abort=1 in READ, WAIT or WRITE: no strobe that cycle, -> IDLE next edge, no done. abort has priority over cpu_req and over start.
- Reset mid-transfer: IDLE on the next edge; no done, no further strobes.
- dram_re and vram_we are never both 1 in the same cycle. Neither is ever 1 while cpu_req=1.

Optional Feature:
MCPU_DMA_FILL_EN
- Defined:
  - If cfg_fill=1 at start: cfg_fill_value is latched, and the FSM goes IDLE -> WRITE directly.
  - Each uncontended WRITE writes the fill value, giving 1 cycle per byte.
  - The vblank input gates every strobe: with vblank=0, READ and WRITE stall exactly as if cpu_req=1.
- Undefined:
  - cfg_fill, cfg_fill_value and vblank are ignored (the ports still exist) and all transfers are copies.
  - No vblank gating.

Test Plan:
- Copy: DRAM[0x100..0x103] low bytes = 0x11,0x22,0x33,0x44; start with src=0x100, dst=0x0040, len=4, cpu_req=0 -> VRAM 0x40..0x43 = 0x11..0x44; vram_we at cycles 3,6,9,12; done=1 at cycle 13 only.
- Contention: same copy with cpu_req=1 on cycles 1-5 -> no DMA strobe in cycles 1-5; the first dram_re is at cycle 6 and the data is still correct; dram_re/vram_we are never high while cpu_req=1.
- Zero length and wrap:
  - len=0 -> done at cycle 1, busy never high, no strobes.
  - src=0x3FFF, dst=0x1FFF, len=2 -> second access uses dram_addr=0x0000 and vram_addr=0x0000.
- Abort/reset: abort in cycle 4 of a len=8 copy -> exactly one vram_we (at cycle 3), no done, busy=0 from cycle 5. Repeat with reset in place of abort -> same result.
- Start while busy: a second start at cycle 2 with different cfg_* values -> ignored; the original transfer completes unchanged.
- With MCPU_DMA_FILL_EN defined:
  - fill=1, value=0xAA, dst=0x10, len=3, vblank=1 -> writes at cycles 1,2,3, done at cycle 4.
  - Same fill with vblank=0 for cycles 1-10 -> first write at cycle 11.
